// File: rtl/adder_pkg.sv
// Shared definitions for the bit-serial adder datapath: controller state
// encodings and the default word length used by the operand shift registers,
// the adder control FSM and the serial-to-parallel collector.
package adder_pkg;

  localparam int ADDER_WIDTH = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

endpackage

// File: rtl/sipo_bit_counter.sv
// Accepted-bit counter for the serial collector. Counts enabled cycles,
// wraps to zero after the last bit of a word and flags the terminal count
// so the collector knows the current bit completes the word.
module sipo_bit_counter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tc = (cnt_q == LAST);

  // Next count: clear wins over enable; the last bit wraps back to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tc ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sipo_collector.sv
// Serial-in/parallel-out collector. Gathers WIDTH bits LSB-first from the
// bit-serial adder and presents the assembled word with a valid/ready
// handshake. A pending word is never overwritten: bits arriving while it
// waits are dropped and flagged through the sticky overrun output.
module sipo_collector
  import adder_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overrun
);

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  // Only WIDTH-1 bits need storing: the final bit goes straight from bit_in
  // into the output word.
  logic [WIDTH-2:0] sreg_q;
  logic [WIDTH-2:0] sreg_d;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] out_d;
  logic [WIDTH-1:0] shifted;
  logic             overrun_q;
  logic             overrun_d;
  logic             cnt_clr;
  logic             cnt_en;
  logic             cnt_tc;

  assign shifted = {bit_in, sreg_q};

  sipo_bit_counter #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk(clk),
    .rst(rst),
    .clr(cnt_clr),
    .en (cnt_en),
    .tc (cnt_tc)
  );

  // Next-state logic: frame arming, bit shifting, word completion and handshake.
  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    out_d     = out_q;
    overrun_d = overrun_q;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sreg_d    = '0;
          cnt_clr   = 1'b1;
          overrun_d = 1'b0;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (start) begin
          // Restart discards any partial word and the bit on this cycle.
          sreg_d    = '0;
          cnt_clr   = 1'b1;
          overrun_d = 1'b0;
        end else if (bit_valid) begin
          sreg_d = shifted[WIDTH-1:1];
          cnt_en = 1'b1;
          if (cnt_tc) begin
            out_d   = shifted;
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (bit_valid) begin
          overrun_d = 1'b1;
        end
        if (out_ready) begin
          if (start) begin
            sreg_d    = '0;
            cnt_clr   = 1'b1;
            overrun_d = 1'b0;
            state_d   = ST_SHIFT;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, shift, output and overrun registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      sreg_q    <= '0;
      out_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      out_q     <= out_d;
      overrun_q <= overrun_d;
    end
  end

  assign out       = out_q;
  assign out_valid = (state_q == ST_HOLD);
  assign busy      = (state_q == ST_SHIFT);
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_sipo_collector.sv
// Bench for sipo_collector (WIDTH=8): directed frames plus randomized traffic
// against a word-level reference model, with completed words queued for a
// separate handshake monitor.
module tb_sipo_collector;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         bit_in;
  logic         bit_valid;
  logic         out_ready;
  logic [W-1:0] out;
  logic         out_valid;
  logic         busy;
  logic         overrun;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sipo_collector #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bit_in   (bit_in),
    .bit_valid(bit_valid),
    .out      (out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy),
    .overrun  (overrun)
  );

  // Reference model: a frame is "collecting" after an accepted start; bits
  // accumulate arithmetically by position; after W bits the word is pending
  // until the consumer takes it.
  logic [W-1:0] exp_q[$];
  bit           m_collect;
  bit           m_pending;
  bit           m_over;
  int           m_n;
  logic [W-1:0] m_acc;
  logic [W-1:0] m_last;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic void model_reset();
    m_collect = 0;
    m_pending = 0;
    m_over    = 0;
    m_n       = 0;
    m_acc     = '0;
    m_last    = '0;
    exp_q.delete();
  endfunction

  function automatic void model_arm();
    m_collect = 1;
    m_n       = 0;
    m_acc     = '0;
    m_over    = 0;
  endfunction

  function automatic void model_step(input bit s, input bit bv, input bit b, input bit r);
    if (m_pending) begin
      if (bv) m_over = 1;
      if (r) begin
        m_pending = 0;
        if (s) model_arm();
      end
    end else if (m_collect) begin
      if (s) begin
        model_arm();
      end else if (bv) begin
        m_acc = m_acc + (W'(b) << m_n);
        m_n++;
        if (m_n == W) begin
          exp_q.push_back(m_acc);
          m_last    = m_acc;
          m_pending = 1;
          m_collect = 0;
        end
      end
    end else if (s) begin
      model_arm();
    end
  endfunction

  // One clock: the DUT and the model see the same inputs, then outputs are compared.
  task automatic cycle();
    @(posedge clk);
    model_step(start, bit_valid, bit_in, out_ready);
    #1;
    check("busy", 32'(busy), 32'(m_collect));
    check("out_valid", 32'(out_valid), 32'(m_pending));
    check("overrun", 32'(overrun), 32'(m_over));
    check("out", 32'(out), 32'(m_last));
  endtask

  task automatic drive(input bit s, input bit bv, input bit b, input bit r);
    start     = s;
    bit_valid = bv;
    bit_in    = b;
    out_ready = r;
    cycle();
  endtask

  task automatic send_word(input logic [W-1:0] w, input bit gaps);
    for (int i = 0; i < W; i++) begin
      if (gaps) drive(0, 0, 0, 0);
      drive(0, 1, w[i], 0);
    end
  endtask

  // Handshake monitor: any presented word must be the oldest expected one;
  // it is retired when the consumer accepts it.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got word %0h, required no word", out);
      end else begin
        check("sb_word", 32'(out), 32'(exp_q[0]));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [W-1:0] w;
    rst       = 1'b1;
    start     = 1'b0;
    bit_in    = 1'b0;
    bit_valid = 1'b0;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_out", 32'(out), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Basic frame
    drive(1, 0, 0, 0);
    send_word(8'h4D, 0);
    check("t1_word", 32'(out), 32'h4D);
    check("t1_valid", 32'(out_valid), 32'h1);
    check("t1_busy", 32'(busy), 32'h0);
    drive(0, 0, 0, 1);
    check("t1_valid_drop", 32'(out_valid), 32'h0);

    // Gapped frame
    drive(1, 0, 0, 0);
    send_word(8'h4D, 1);
    check("t2_word", 32'(out), 32'h4D);
    drive(0, 0, 0, 1);

    // Backpressure and overrun
    drive(1, 0, 0, 0);
    send_word(8'hFF, 0);
    repeat (3) drive(0, 1, 0, 0);
    check("t3_hold_word", 32'(out), 32'hFF);
    check("t3_overrun", 32'(overrun), 32'h1);
    drive(1, 0, 0, 0);
    check("t3_start_ignored", 32'(out_valid), 32'h1);
    drive(0, 0, 0, 1);
    check("t3_overrun_idle", 32'(overrun), 32'h1);
    drive(1, 0, 0, 0);
    check("t3_overrun_clr", 32'(overrun), 32'h0);

    // Restart mid-frame
    drive(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) drive(0, 1, 1'($urandom), 0);
    drive(1, 1, 1, 0);
    send_word(8'hA5, 0);
    check("t4_word", 32'(out), 32'hA5);
    drive(0, 0, 0, 1);

    // Back-to-back frames
    drive(1, 0, 0, 0);
    send_word(W'($urandom), 0);
    drive(1, 0, 0, 1);
    check("t5_busy", 32'(busy), 32'h1);
    send_word(8'h3C, 0);
    check("t5_word", 32'(out), 32'h3C);
    drive(0, 0, 0, 1);

    // Asynchronous reset mid-frame
    drive(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 1, 1, 0);
    #2 rst = 1'b1;
    #1;
    check("t6_busy", 32'(busy), 32'h0);
    check("t6_valid", 32'(out_valid), 32'h0);
    check("t6_out", 32'(out), 32'h0);
    check("t6_overrun", 32'(overrun), 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) drive(0, 1, 1'($urandom), 1);
    check("t6_no_valid", 32'(out_valid), 32'h0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 15) == 0), ($urandom_range(0, 9) < 7),
            1'($urandom), 1'($urandom));
    end
    repeat (3) drive(0, 0, 0, 1);
    check("sb_drained", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
